// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, register-specifier
// width and the NOP word loaded into IF/ID on a flush.
package pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// W-bit saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_r;

  // Count register: increment when enabled unless already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (en && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/freeze/halt control for the 5-stage core (Mealy control outputs).
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = pipe_pkg::REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  state_t state_r;
  state_t state_nxt_s;
  logic   load_use_s;
  logic   pc_we_s;
  logic   ifid_we_s;
  logic   ifid_flush_s;
  logic   idex_flush_s;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use_s = ex_memread && (ex_rt != {REG_W{1'b0}}) &&
                      ((id_uses_rs && (id_rs == ex_rt)) ||
                       (id_uses_rt && (id_rt == ex_rt)));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and prioritised control outputs.
  always_comb begin
    state_nxt_s  = ST_RUN;
    pc_we_s      = 1'b0;
    ifid_we_s    = 1'b0;
    ifid_flush_s = 1'b1;
    idex_flush_s = 1'b1;
    if (rst) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_HALT: begin
          ifid_flush_s = 1'b0;
          idex_flush_s = 1'b1;
          if (resume && !halt_req) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        ST_RUN, ST_WAIT: begin
          if (halt_req) begin
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b1;
            state_nxt_s  = ST_HALT;
          end else if (mem_busy) begin
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b0;
            state_nxt_s  = ST_WAIT;
          end else if (ex_branch_taken) begin
            // IF/ID write is enabled but the flush overrides it.
            pc_we_s      = 1'b1;
            ifid_we_s    = 1'b1;
            ifid_flush_s = 1'b1;
            idex_flush_s = 1'b1;
          end else if (load_use_s) begin
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b1;
          end else begin
            pc_we_s      = 1'b1;
            ifid_we_s    = 1'b1;
            ifid_flush_s = 1'b0;
            idex_flush_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
        end
      endcase
    end
  end

  assign pc_we      = pc_we_s;
  assign ifid_we    = ifid_we_s;
  assign ifid_flush = ifid_flush_s;
  assign idex_flush = idex_flush_s;
  assign state      = state_r;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_en_s;
  logic flush_en_s;

  assign stall_en_s = !rst && !pc_we_s;
  assign flush_en_s = !rst && (state_r != ST_HALT) && !halt_req && !mem_busy &&
                      ex_branch_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_en_s),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_en_s),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int RW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken;
  logic          mem_busy, halt_req, resume;
  logic          pc_we, ifid_we, ifid_flush, idex_flush;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .state(state)
  );

  typedef struct packed {
    logic          pc_we;
    logic          ifid_we;
    logic          ifid_flush;
    logic          idex_flush;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // Model state: 0 running, 1 waiting on memory, 2 halted.
  int m_state = 0;
  int m_sc    = 0;
  int m_fc    = 0;

  logic          n_rst, n_urs, n_urt, n_mr, n_bt, n_mb, n_hr, n_res;
  logic [RW-1:0] n_rs, n_rt, n_ert;

  task automatic idle();
    n_rst = 1'b0; n_urs = 1'b0; n_urt = 1'b0; n_mr = 1'b0; n_bt = 1'b0;
    n_mb = 1'b0; n_hr = 1'b0; n_res = 1'b0;
    n_rs = '0; n_rt = '0; n_ert = '0;
  endtask

  // Apply staged inputs after the edge, predict this cycle, advance the model.
  task automatic step();
    exp_t e;
    bit   lu;
    bit   flush_evt;
    int   nxt;
    @(posedge clk);
    #1;
    rst = n_rst; id_rs = n_rs; id_rt = n_rt; id_uses_rs = n_urs; id_uses_rt = n_urt;
    ex_memread = n_mr; ex_rt = n_ert; ex_branch_taken = n_bt; mem_busy = n_mb;
    halt_req = n_hr; resume = n_res;
    flush_evt = 1'b0;
    if (n_rst) begin
      m_state = 0; m_sc = 0; m_fc = 0;
      e = '{pc_we:1'b0, ifid_we:1'b0, ifid_flush:1'b1, idex_flush:1'b1,
            st:2'd0, sc:'0, fc:'0};
      q.push_back(e);
    end else begin
      lu = n_mr && (n_ert != 0) &&
           ((n_urs && (n_rs == n_ert)) || (n_urt && (n_rt == n_ert)));
      e.st = 2'(m_state);
`ifdef HAZARD_PERF_CNT_EN
      e.sc = CW'(m_sc);
      e.fc = CW'(m_fc);
`else
      e.sc = '0;
      e.fc = '0;
`endif
      if (m_state == 2) begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b0001;
        nxt = (n_res && !n_hr) ? 0 : 2;
      end else if (n_hr) begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b0001;
        nxt = 2;
      end else if (n_mb) begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b0000;
        nxt = 1;
      end else if (n_bt) begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b1111;
        nxt = 0;
        flush_evt = 1'b1;
      end else if (lu) begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b0001;
        nxt = 0;
      end else begin
        {e.pc_we, e.ifid_we, e.ifid_flush, e.idex_flush} = 4'b1100;
        nxt = 0;
      end
      q.push_back(e);
      if (!e.pc_we && m_sc < SAT) m_sc = m_sc + 1;
      if (flush_evt && m_fc < SAT) m_fc = m_fc + 1;
      m_state = nxt;
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc_we", int'(pc_we), int'(e.pc_we));
      chk("ifid_flush", int'(ifid_flush), int'(e.ifid_flush));
      chk("idex_flush", int'(idex_flush), int'(e.idex_flush));
      if (!e.ifid_flush) chk("ifid_we", int'(ifid_we), int'(e.ifid_we));
      chk("state", int'(state), int'(e.st));
      chk("stall_cnt", int'(stall_cnt), int'(e.sc));
      chk("flush_cnt", int'(flush_cnt), int'(e.fc));
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
    idle();
    n_rst = 1'b1; step(); step();
    idle(); step();
    // Load-use on rs, then clear; repeat against r0.
    n_mr = 1'b1; n_ert = 5'd8; n_rs = 5'd8; n_urs = 1'b1; step();
    idle(); step();
    n_mr = 1'b1; n_ert = 5'd0; n_rs = 5'd0; n_urs = 1'b1; step();
    idle(); n_mr = 1'b1; n_ert = 5'd9; n_rt = 5'd9; n_urt = 1'b1; step();
    // Branch together with a load-use.
    idle(); n_mr = 1'b1; n_ert = 5'd8; n_rs = 5'd8; n_urs = 1'b1; n_bt = 1'b1; step();
    // Memory freeze with a pending branch.
    idle(); n_mb = 1'b1; n_bt = 1'b1; step(); step(); step();
    n_mb = 1'b0; step();
    idle(); step();
    // Halt, resume blocked by halt_req, then resume.
    n_hr = 1'b1; n_mb = 1'b1; step();
    idle(); n_bt = 1'b1; n_mb = 1'b1; step();
    idle(); n_hr = 1'b1; n_res = 1'b1; step();
    idle(); n_res = 1'b1; step();
    idle(); step();
    // Reset while halted.
    n_hr = 1'b1; step();
    idle(); step();
    n_rst = 1'b1; step(); step();
    idle(); step();
    // Saturation of the stall counter.
    n_mb = 1'b1;
    for (int i = 0; i < 20; i++) step();
    idle(); step();
    for (int i = 0; i < 20; i++) begin
      n_bt = 1'b1; step();
    end
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      n_rst = ($urandom_range(0, 63) == 0);
      n_hr  = ($urandom_range(0, 15) == 0);
      n_res = ($urandom_range(0, 3) == 0);
      n_mb  = ($urandom_range(0, 5) == 0);
      n_bt  = ($urandom_range(0, 4) == 0);
      n_mr  = $urandom_range(0, 1);
      n_urs = $urandom_range(0, 1);
      n_urt = $urandom_range(0, 1);
      n_rs  = RW'($urandom_range(0, 3));
      n_rt  = RW'($urandom_range(0, 3));
      n_ert = RW'($urandom_range(0, 3));
      step();
    end
    idle(); step();
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
